// File: rtl/seq_compare.sv
// Multi-cycle magnitude comparator: walks the operands one CHUNK at a time from
// the most significant end and stops at the first chunk that differs.
module seq_compare #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             less,
  output logic             greater
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_equal;
  logic             r_less;
  logic             r_greater;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_lt;
  logic             w_ne;

  // Current chunk of each latched operand. For a signed compare, flipping the
  // sign bit of the MSB chunk maps two's-complement order onto unsigned order.
  // NOTE: every always_comb output is assigned before any condition so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_ca = r_a[int'(r_idx)*CHUNK +: CHUNK];
    w_cb = r_b[int'(r_idx)*CHUNK +: CHUNK];
    if (r_signed && (r_idx == MSB_IDX)) begin
      w_ca[CHUNK-1] = ~w_ca[CHUNK-1];
      w_cb[CHUNK-1] = ~w_cb[CHUNK-1];
    end
  end

  assign w_lt = (w_ca < w_cb);
  assign w_ne = (w_ca != w_cb);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_equal   <= 1'b0;
      r_less    <= 1'b0;
      r_greater <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= is_signed;
            r_idx    <= MSB_IDX;
            r_busy   <= 1'b1;
            r_state  <= S_CMP;
          end else begin
            r_state  <= S_IDLE;
          end
        end

        S_CMP: begin
          // Result flags keep the previous answer until this compare decides.
          if (w_ne) begin
            r_equal   <= 1'b0;
            r_less    <= w_lt;
            r_greater <= ~w_lt;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_idx == '0) begin
            r_equal   <= 1'b1;
            r_less    <= 1'b0;
            r_greater <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx     <= r_idx - IW'(1);
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign equal   = r_equal;
  assign less    = r_less;
  assign greater = r_greater;

endmodule

// File: tb/tb_seq_compare.sv
// Scoreboard bench for seq_compare: expected flags and latency are queued at
// each accepted start and retired by a monitor on every done pulse.
module tb_seq_compare;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             equal;
  logic             less;
  logic             greater;

  typedef struct {
    logic [2:0] flags;      // {equal, less, greater}
    int         lat;
    int         start_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_vec;
  int   n_miss;

  seq_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .equal     (equal),
    .less      (less),
    .greater   (greater)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             s);
    logic lt;
    if (x == y) return 3'b100;
    lt = s ? ($signed(x) < $signed(y)) : (x < y);
    return lt ? 3'b010 : 3'b001;
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int m;
    m = 1;
    for (int i = NCH - 1; i > 0; i--) begin
      if (x[i*CHUNK +: CHUNK] != y[i*CHUNK +: CHUNK]) break;
      m++;
    end
    return m;
  endfunction

  // Monitor: flags must hold while busy; each done retires one scoreboard entry.
  initial begin
    int         busy_cnt;
    logic [2:0] last_flags;
    exp_t       e;
    busy_cnt   = 0;
    last_flags = 3'b000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt   = 0;
        last_flags = 3'b000;
      end else begin
        if (busy) begin
          check("flags_hold", {29'd0, equal, less, greater}, {29'd0, last_flags});
          busy_cnt++;
        end
        if (done) begin
          check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("flags", {29'd0, equal, less, greater}, {29'd0, e.flags});
            check("latency", cyc - e.start_cyc, e.lat);
            check("busy_cycles", busy_cnt, e.lat);
            check("busy_in_done", {31'd0, busy}, 32'd0);
          end
          busy_cnt   = 0;
          last_flags = {equal, less, greater};
        end
      end
    end
  end

  // Called at a negedge; returns 1 ns after the accepting rising edge.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic s, input logic [2:0] flags, input int lat);
    exp_t e;
    a         = x;
    b         = y;
    is_signed = s;
    start     = 1'b1;
    e.flags     = flags;
    e.lat       = lat;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    issue(x, y, s, model_flags(x, y, s), model_lat(x, y));
  endtask

  // Returns at the negedge where done is high, or flags a timeout.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * NCH + 4 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] mask;
    int               k;

    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_equal",   {31'd0, equal},   32'd0);
    check("rst_less",    {31'd0, less},    32'd0);
    check("rst_greater", {31'd0, greater}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MSB chunk decides: unsigned vs signed reading of all-ones.
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3'b001, 1);
    wait_done();
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3'b010, 1);
    wait_done();
    @(negedge clk);

    // Full-length equal compare, then a second one started in the DONE cycle.
    issue(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 3'b100, 4);
    wait_done();
    issue(32'h1111_AAAA, 32'h1111_AAAA, 1'b0, 3'b100, 4);
    wait_done();
    @(negedge clk);

    issue(32'hFFF7_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b010, 2);
    wait_done();
    @(negedge clk);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b010, 1);
    wait_done();
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b001, 1);
    wait_done();
    @(negedge clk);

    // A second start one cycle into CMP must be ignored.
    issue(32'h1234_5678, 32'h1234_5678, 1'b0, 3'b100, 4);
    @(negedge clk);
    a         = 32'h0000_0001;
    b         = 32'hFFFF_FFFF;
    is_signed = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (3) begin
      @(negedge clk);
      check("no_extra_done", {31'd0, done}, 32'd0);
    end
    check("sb_drained", sb.size(), 32'd0);

    // Reset two cycles into an equal compare aborts it with no done pulse.
    issue(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 3'b100, 4);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 check("async_rst_outs", {27'd0, busy, done, equal, less, greater}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (NCH + 2) begin
      @(negedge clk);
      check("post_rst_no_done", {31'd0, done}, 32'd0);
    end
    issue(32'hCAFE_0001, 32'hCAFE_0002, 1'b0, 3'b010, 4);
    wait_done();
    @(negedge clk);

    // Random sweep with a controlled number of matching MSB chunks.
    for (int n = 0; n < 1200; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      k    = $urandom_range(0, NCH);
      mask = (k == 0) ? '0 : (~32'h0 << (WIDTH - k * CHUNK));
      rb   = (ra & mask) | (rb & ~mask);
      issue_model(ra, rb, 1'($urandom_range(0, 1)));
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("sb_final_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
